// File: rtl/bus_rx_endpoint_pkg.sv
// Shared constants and helpers for the bus receive endpoint.
package bus_rx_endpoint_pkg;

    localparam int unsigned id_w  = 8;
    localparam int unsigned cnt_w = 16;
    localparam logic [id_w-1:0] bcast_id = 8'hFF;

    // Saturating increment for the event counters.
    function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
        return (v == '1) ? v : v + cnt_w'(1);
    endfunction

endpackage

// File: rtl/bus_rx_endpoint_rx_fifo.sv
// Receive FIFO with explicit occupancy count and a registered head output.
module rx_fifo #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [width-1:0]           wr_data,
    input  logic                       pop,
    output logic [width-1:0]           rd_data,
    output logic [$clog2(depth):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       valid
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = aw + 1;

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [cw-1:0]    count_n;
    logic [width-1:0] head_n;
    logic             do_pop, do_wr;

    // A write into a full FIFO is only allowed when the head leaves on the same edge.
    always_comb begin
        do_pop   = 1'b0;
        do_wr    = 1'b0;
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        count_n  = count;
        head_n   = '0;

        do_pop = pop && valid;
        do_wr  = wr_en && (!full || do_pop);

        if (do_pop) rd_ptr_n = rd_ptr + aw'(1);
        if (do_wr)  wr_ptr_n = wr_ptr + aw'(1);
        count_n = count + cw'(do_wr) - cw'(do_pop);

        // Head bypasses the array when the incoming packet becomes the only entry.
        if (count_n == '0)
            head_n = '0;
        else if (count == cw'(do_pop))
            head_n = wr_data;
        else
            head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            valid   <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ptr  <= rd_ptr_n;
            wr_ptr  <= wr_ptr_n;
            count   <= count_n;
            full    <= (count_n == cw'(depth));
            empty   <= (count_n == '0);
            valid   <= (count_n != '0);
            rd_data <= head_n;
        end
    end

endmodule

// File: rtl/bus_rx_endpoint.sv
// Bus receive endpoint: destination filter, receive FIFO, drop and miss counters.
module bus_rx_endpoint
    import bus_rx_endpoint_pkg::*;
#(
    parameter int unsigned drvrs   = 4,
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned depth   = 8,
    parameter int unsigned id      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [pckg_sz-1:0]     rd_data,
    output logic                   full,
    output logic [$clog2(depth):0] count,
    output logic [cnt_w-1:0]       drop_cnt,
    output logic [cnt_w-1:0]       miss_cnt
);

    if (id >= drvrs || depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_cfg
        $error("bus_rx_endpoint: id must be < drvrs and depth a power of 2 >= 2");
    end

    logic [id_w-1:0] dest_id;
    logic            match_c, accept_c, pop_c, drop_c, miss_c;
    logic            fifo_empty;

    always_comb begin
        dest_id  = D_push[pckg_sz-1 -: id_w];
        match_c  = (dest_id == id_w'(id)) || (dest_id == bcast_id);
        accept_c = push && match_c;
        miss_c   = push && !match_c;
        pop_c    = rd_valid && rd_ready;
        drop_c   = accept_c && full && !pop_c;
    end

    rx_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (accept_c),
        .wr_data (D_push),
        .pop     (pop_c),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (fifo_empty),
        .valid   (rd_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (drop_c) drop_cnt <= sat_inc(drop_cnt);
            if (miss_c) miss_cnt <= sat_inc(miss_cnt);
        end
    end

    // Empty flag is redundant with rd_valid at this level.
    logic unused_ok;
    assign unused_ok = fifo_empty;

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Randomised and directed bench for bus_rx_endpoint against a queue-based model.
module tb_bus_rx_endpoint;

    localparam int unsigned DRVRS = 4;
    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned ID    = 0;

    logic          clk;
    logic          reset;
    logic          push;
    logic [PW-1:0] D_push;
    logic          rd_valid;
    logic          rd_ready;
    logic [PW-1:0] rd_data;
    logic          full;
    logic [3:0]    count;
    logic [15:0]   drop_cnt;
    logic [15:0]   miss_cnt;

    int vectors    = 0;
    int miscompares = 0;

    logic [PW-1:0] m_q[$];
    int            m_drop = 0;
    int            m_miss = 0;

    bus_rx_endpoint #(
        .drvrs   (DRVRS),
        .pckg_sz (PW),
        .depth   (DEPTH),
        .id      (ID)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .D_push   (D_push),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .full     (full),
        .count    (count),
        .drop_cnt (drop_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
        check("count",    32'(count),    32'(m_q.size()));
        check("full",     32'(full),     32'(m_q.size() == DEPTH));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        if (m_q.size() != 0)
            check("rd_data", 32'(rd_data), 32'(m_q[0]));
    endtask

    // One clock: drive, let the edge happen, advance the model, then compare.
    task automatic step(input logic p, input logic [PW-1:0] d, input logic rr);
        logic       hit, pop, room;
        logic [7:0] dst;
        push     = p;
        D_push   = d;
        rd_ready = rr;
        @(posedge clk);
        dst  = d[PW-1 -: 8];
        hit  = p && (dst == 8'(ID) || dst == 8'hFF);
        pop  = rr && (m_q.size() != 0);
        room = (m_q.size() < DEPTH) || pop;
        if (pop) void'(m_q.pop_front());
        if (hit && room) m_q.push_back(d);
        else if (hit && m_drop < 16'hFFFF) m_drop++;
        if (p && !hit && m_miss < 16'hFFFF) m_miss++;
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m_q.delete();
        m_drop = 0;
        m_miss = 0;
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [7:0] dst;
        case ($urandom_range(0, 3))
            0:       dst = 8'(ID);
            1:       dst = 8'hFF;
            2:       dst = 8'($urandom_range(1, 254));
            default: dst = 8'($urandom_range(0, 255));
        endcase
        return {dst, 8'($urandom_range(0, 255))};
    endfunction

    initial begin
        reset    = 1'b0;
        push     = 1'b0;
        D_push   = '0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_full",  32'(full),     32'd0);
        check("rst_data",  32'(rd_data),  32'd0);
        check("rst_count", 32'(count),    32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Unicast then filter
        step(1'b1, 16'h0042, 1'b0);
        check("uni_data", 32'(rd_data), 32'h0042);
        check("uni_count", 32'(count), 32'd1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h0342, 1'b0);
        check("filt_miss", 32'(miss_cnt), 32'd1);
        check("filt_valid", 32'(rd_valid), 32'd0);
        step(1'b1, 16'hFF11, 1'b0);
        check("bcast_data", 32'(rd_data), 32'hFF11);
        step(1'b0, 16'h0000, 1'b1);

        // Overflow: 9 matching pushes into depth 8
        for (int i = 0; i < 9; i++) step(1'b1, 16'(16'h0010 + i), 1'b0);
        check("ovf_full",  32'(full),     32'd1);
        check("ovf_count", 32'(count),    32'd8);
        check("ovf_drop",  32'(drop_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("ovf_order", 32'(rd_data), 32'(16'h0010 + i));
            step(1'b0, 16'h0000, 1'b1);
        end
        check("ovf_empty", 32'(rd_valid), 32'd0);

        // Full plus simultaneous push and pop
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0020 + i), 1'b0);
        step(1'b1, 16'h00AA, 1'b1);
        check("fullsim_count", 32'(count),    32'd8);
        check("fullsim_drop",  32'(drop_cnt), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 16'h0000, 1'b1);
        check("fullsim_last", 32'(rd_data), 32'h00AA);
        step(1'b0, 16'h0000, 1'b1);

        // count=1 with simultaneous push and pop
        step(1'b1, 16'h0051, 1'b0);
        step(1'b1, 16'h0052, 1'b1);
        check("one_sim_data", 32'(rd_data), 32'h0052);
        step(1'b0, 16'h0000, 1'b1);

        // Reset pulsed between edges with five queued
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0030 + i), 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", 32'(rd_valid), 32'd0);
        check("midrst_count", 32'(count),    32'd0);
        check("midrst_data",  32'(rd_data),  32'd0);
        #2 reset = 1'b1;
        model_reset();
        step(1'b0, 16'h0000, 1'b0);
        check("midrst_drop", 32'(drop_cnt), 32'd0);
        check("midrst_miss", 32'(miss_cnt), 32'd0);

        // Push held during reset is ignored
        step(1'b1, 16'h0061, 1'b0);
        reset  = 1'b0;
        push   = 1'b1;
        D_push = 16'h0062;
        @(posedge clk);
        #1;
        check("rstpush_count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(1'b0, 16'h0000, 1'b0);

        // Empty pops are ignored
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b1);
        check("empty_pop_count", 32'(count), 32'd0);

        // Randomised traffic with alternating consumer pressure
        for (int i = 0; i < 2000; i++) begin
            logic p, rr;
            p  = ($urandom_range(0, 9) < 6);
            rr = (i < 1000) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            step(p, rand_pkt(), rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
